// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch controller: FSM state and fetch-mux selects.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StDrain    = 2'd1,
        StEretWait = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PCSEL_PC4 = 2'b00,
        PCSEL_NPC = 2'b01,
        PCSEL_RF  = 2'b10
    } pc_sel_e;

    typedef enum logic [1:0] {
        EXCSEL_PIPE    = 2'b00,
        EXCSEL_HANDLER = 2'b01,
        EXCSEL_EPC     = 2'b10
    } exc_sel_e;

    localparam int unsigned DrainCntW = 4;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: stalled cycles and redirected fetch cycles, both wrapping.
module fetch_perf_cnt (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pc_en_i,
    input  logic        redirect_i,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] redirect_cnt_o
);

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        if (!pc_en_i) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (pc_en_i && redirect_i) begin
            redirect_cnt_d = redirect_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign stall_cnt_o    = stall_cnt_q;
    assign redirect_cnt_o = redirect_cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC source selection, exception entry/drain and eret sequencing.
// Optional performance counters are enabled with FETCH_CTRL_PERF_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall_ID,
    input  logic       branch_ID,
    input  logic       jr_ID,
    input  logic       exc_req,
    input  logic       eret_req,
    output logic [1:0] PC_sel,
    output logic [1:0] PC_EXC_sel,
    output logic       pc_en,
    output logic       flush_IF_ID,
    output logic       flush_all,
    output logic       exc_busy
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] redirect_cnt
`endif
);

    localparam logic [DrainCntW-1:0] DrainLoad = DrainCntW'(DRAIN_CYCLES - 1);

    fetch_state_e         state_q, state_d;
    logic [DrainCntW-1:0] cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    pc_sel_e              pc_sel;
    exc_sel_e             exc_sel;
    logic                 exc_take;

    // A deferred request is honoured exactly like a live one on the first RUN cycle.
    assign exc_take = exc_req | pend_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        unique case (state_q)
            StRun: begin
                if (exc_take) begin
                    state_d = StDrain;
                    cnt_d   = DrainLoad;
                    pend_d  = 1'b0;
                end else if (eret_req && !stall_ID) begin
                    state_d = StEretWait;
                end
            end
            StDrain: begin
                pend_d = pend_q | exc_req;
                if (cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StEretWait: begin
                pend_d  = pend_q | exc_req;
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        pc_sel      = PCSEL_PC4;
        exc_sel     = EXCSEL_PIPE;
        pc_en       = 1'b0;
        flush_IF_ID = 1'b0;
        flush_all   = 1'b0;
        exc_busy    = 1'b0;
        if (!reset) begin
            if (jr_ID) begin
                pc_sel = PCSEL_RF;
            end else if (branch_ID) begin
                pc_sel = PCSEL_NPC;
            end
            pc_en = ~stall_ID;
            unique case (state_q)
                StRun: begin
                    if (exc_take) begin
                        pc_sel    = PCSEL_PC4;
                        exc_sel   = EXCSEL_HANDLER;
                        pc_en     = 1'b1;
                        flush_all = 1'b1;
                    end else if (eret_req) begin
                        pc_sel = PCSEL_PC4;
                        if (!stall_ID) begin
                            exc_sel     = EXCSEL_EPC;
                            flush_IF_ID = 1'b1;
                        end
                    end
                end
                StDrain:    exc_busy = 1'b1;
                StEretWait: ;
                default:    ;
            endcase
        end
    end

    assign PC_sel     = pc_sel;
    assign PC_EXC_sel = exc_sel;

`ifdef FETCH_CTRL_PERF_EN
    fetch_perf_cnt u_perf (
        .clk_i          (clk),
        .reset_i        (reset),
        .pc_en_i        (pc_en),
        .redirect_i     ((PC_sel != 2'b00) || (PC_EXC_sel != 2'b00)),
        .stall_cnt_o    (stall_cnt),
        .redirect_cnt_o (redirect_cnt)
    );
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, meaning post-exception-entry cycles during which new redirects are deferred (range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall_ID  input  1  hazard stall request from ID.
REQ-005 SHALL have port branch_ID  input  1  taken branch/j/jal in ID, select NPC.
REQ-006 SHALL have port jr_ID  input  1  jr/jalr in ID, select RF output.
REQ-007 SHALL have port exc_req  input  1  exception/interrupt request from CP0.
REQ-008 SHALL have port eret_req  input  1  eret decoded in ID.
REQ-009 SHALL have port PC_sel  output  2  to fetch mux: 00 PC+4, 01 NPC, 10 RF output.
REQ-010 SHALL have port PC_EXC_sel  output  2  to fetch mux: 00 pipeline PC, 01 handler 0x00004180, 10 EPC.
REQ-011 SHALL have port pc_en  output  1  PC register write enable.
REQ-012 SHALL have port flush_IF_ID  output  1  clear the IF/ID register.
REQ-013 SHALL have port flush_all  output  1  clear all pipeline registers.
REQ-014 SHALL have port exc_busy  output  1  high in state DRAIN.

Function
REQ-015 SHALL implement a 3-state FSM: RUN, DRAIN, ERET_WAIT; outputs decoded combinationally from state, inputs and the pending flag.
REQ-016 In RUN with exc_req or pend=1: PC_EXC_sel=01, pc_en=1, flush_all=1, PC_sel=00, clear pend; next state DRAIN with counter loaded to DRAIN_CYCLES-1.
REQ-017 In RUN with no exception and eret_req=1 and stall_ID=0: PC_EXC_sel=10, pc_en=1, flush_IF_ID=1; next state ERET_WAIT.
REQ-018 In RUN with eret_req=1 and stall_ID=1: pc_en=0, PC_EXC_sel=00; eret is not taken and state remains RUN.
REQ-019 In RUN otherwise: pc_en=~stall_ID; PC_sel=10 if jr_ID, else 01 if branch_ID, else 00; PC_EXC_sel=00.
REQ-020 Priority SHALL be exception/pending > eret > jr > branch > sequential; exc_req overrides stall_ID.
REQ-021 In DRAIN: pc_en=~stall_ID, PC_EXC_sel=00, PC_sel per REQ-019; eret_req is ignored; exc_req sets pend (sticky 1-bit).
REQ-022 The DRAIN counter SHALL decrement each cycle; transition to RUN on the cycle the counter equals 0; duration exactly DRAIN_CYCLES cycles.
REQ-023 ERET_WAIT SHALL last exactly 1 cycle: pc_en=~stall_ID, PC_EXC_sel=00, eret_req ignored, exc_req sets pend; then go to RUN.
REQ-024 A pend set in DRAIN/ERET_WAIT SHALL be taken on the first RUN cycle (REQ-016); multiple requests collapse into one.
REQ-025 flush_all and flush_IF_ID SHALL be single-cycle pulses, never both high in the same cycle.

Reset
REQ-026 While reset=1 on a clock edge: state<=RUN, pend<=0, counter<=0, perf counters<=0.
REQ-027 While reset=1, outputs SHALL be pc_en=0, PC_sel=00, PC_EXC_sel=00, flush_IF_ID=0, flush_all=0, exc_busy=0, regardless of other inputs.
REQ-028 Reset asserted mid-DRAIN SHALL discard the drain and pend; no exception entry follows.

Configuration
REQ-029 With FETCH_CTRL_PERF_EN defined: add outputs stall_cnt[31:0] (cycles with pc_en=0, reset excluded) and redirect_cnt[31:0] (cycles with PC_sel!=00 or PC_EXC_sel!=00 and pc_en=1), both wrapping at 2^32.
REQ-030 Without FETCH_CTRL_PERF_EN: these ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-031 A shared package fetch_ctrl_pkg SHALL hold the FSM state encoding and the PC_sel/PC_EXC_sel encodings (PCSEL_PC4/NPC/RF, EXCSEL_PIPE/HANDLER/EPC).
REQ-032 Performance counters SHALL live in sub-module fetch_perf_cnt, instantiated only under FETCH_CTRL_PERF_EN.

Verification
REQ-033 Reset, then idle inputs -> pc_en=1, PC_sel=00, PC_EXC_sel=00 from the first cycle after reset.
REQ-034 branch_ID=1 and jr_ID=1 together with stall_ID=0 -> PC_sel=10; same inputs with stall_ID=1 -> pc_en=0.
REQ-035 exc_req=1 with stall_ID=1 and eret_req=1 -> PC_EXC_sel=01, pc_en=1, flush_all=1; exc_busy=1 for exactly 3 cycles (DRAIN_CYCLES=3).
REQ-036 exc_req pulsed in the 2nd DRAIN cycle -> second handler entry (PC_EXC_sel=01) on the first RUN cycle after the drain.
REQ-037 eret_req held high for 3 cycles -> exactly one PC_EXC_sel=10 pulse with flush_IF_ID=1, then ERET_WAIT, then a second eret taken in RUN.
REQ-038 reset asserted in the 1st DRAIN cycle with pend set -> RUN afterwards, no flush_all pulse, counters=0 (with FETCH_CTRL_PERF_EN).
